// File: rtl/en_2_4_s.sv
// rtl/en_2_4_s.sv - registered 4-to-2 priority encoder with valid and multi-hot error flags
module en_2_4_s (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [1:0] a,
    output logic       v,
    output logic       err
);

    logic [1:0] w_a;
    logic       w_v;
    logic       w_err;
    logic [1:0] r_a;
    logic       r_v;
    logic       r_err;

    // Highest set index wins; an all-zero sample encodes as 00 and is told apart only by v.
    always_comb begin
        w_a = 2'b00;
        if (d[3])      w_a = 2'b11;
        else if (d[2]) w_a = 2'b10;
        else if (d[1]) w_a = 2'b01;
        else           w_a = 2'b00;
    end

    assign w_v = |d;

    // Two or more bits set: any pair of request lines both high.
    assign w_err = (d[3] & (d[2] | d[1] | d[0]))
                 | (d[2] & (d[1] | d[0]))
                 | (d[1] & d[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= 2'b00;
            r_v   <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_a   <= w_a;
            r_v   <= w_v;
            r_err <= w_err;
        end
    end

    assign a   = r_a;
    assign v   = r_v;
    assign err = r_err;

endmodule

// File: tb/tb_en_2_4_s.sv
// tb/tb_en_2_4_s.sv - scoreboard bench for en_2_4_s with a behavioural priority-encoder model
module tb_en_2_4_s;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic [1:0] a;
    logic       v;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_q[$];

    en_2_4_s dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .a   (a),
        .v   (v),
        .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {a, v, err} from the rules: index of highest set bit, any bit set, popcount >= 2.
    function automatic logic [3:0] model(input logic [3:0] x);
        int hi;
        int cnt;
        logic [1:0] ea;
        hi  = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) begin
                hi  = i;
                cnt = cnt + 1;
            end
        end
        ea = 2'(hi);
        return {ea, cnt > 0, cnt >= 2};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got a/v/err=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check("scoreboard", {a, v, err}, exp_q.pop_front());
    end

    task automatic drive(input logic [3:0] x);
        @(negedge clk);
        d = x;
        exp_q.push_back(model(x));
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        d   = 4'b0000;
        #3;
        check("reset_state", {a, v, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        begin
            logic [3:0] sweep [5];
            sweep = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
            for (int i = 0; i < 5; i++) drive(sweep[i]);
        end
        drive(4'b1111);
        drive(4'b0110);
        drive(4'b0011);
        drive(4'b1010);
        for (int i = 0; i < 16; i++) drive(4'(i));
        drain();

        // Latency: a mid-cycle change of d must not reach a before the next edge.
        drive(4'b1000);
        @(posedge clk);
        #2;
        d = 4'b0001;
        exp_q.push_back(model(4'b0001));
        #2;
        check("latency_hold", {a, v, err}, 4'b1110);
        drain();

        // Asynchronous reset between edges while a=11.
        drive(4'b1001);
        drain();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", {a, v, err}, 4'b0000);

        // Edges during reset must not load d.
        d = 4'b0100;
        @(posedge clk);
        #1;
        check("reset_blocks_load", {a, v, err}, 4'b0000);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_before_edge", {a, v, err}, 4'b0000);
        exp_q.push_back(model(4'b0100));
        drain();

        for (int i = 0; i < 200; i++) drive(4'($urandom_range(0, 15)));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/en_2_4_s.md
EN_2_4_S -- requirements
Module: en_2_4_s

Interface
REQ-001 The block SHALL have no parameters; input width is fixed at 4 bits and code width at 2 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 d  input  4  request lines d[3:0]; d[3] has the highest priority.
REQ-005 a  output  2  registered binary code of the selected request line.
REQ-006 v  output  1  registered valid flag; 1 when at least one bit of d was set.
REQ-007 err  output  1  registered flag; 1 when more than one bit of d was set.

Function
REQ-008 On each rising clk edge with rst low, the block SHALL sample d and load a, v and err from that sample.
REQ-009 Latency SHALL be exactly 1 cycle: outputs reflect the d value sampled at the most recent clk edge and hold until the next edge.
REQ-010 Required one-hot mapping: d=1000 gives a=11; d=0100 gives a=10; d=0010 gives a=01; d=0001 gives a=00.
REQ-011 Multi-hot d SHALL be priority-encoded, with the highest set index winning. Example: d=1010 gives a=11; d=0011 gives a=01.
REQ-012 For d=0000 the block SHALL load a=00 and v=0.
REQ-013 v SHALL equal the OR of all d bits in the sample.
REQ-014 err SHALL be 1 when two or more d bits are set in the sample, and 0 otherwise. When err=1, a still follows REQ-011.
REQ-015 The block SHALL have no handshake and no backpressure; a new sample is taken on every cycle.
REQ-016 a=00 SHALL be distinguished between the d=0001 and d=0000 cases only by v (v=1 and v=0 respectively).
REQ-017 The block SHALL have no internal state other than the a, v and err registers. Output SHALL not depend on earlier samples.
REQ-018 X or Z on d is out of scope. Behaviour for such inputs is not required.

Reset
REQ-019 While rst=1, the outputs SHALL be a=00, v=0 and err=0 immediately, with no clock edge required.
REQ-020 rst asserted mid-operation SHALL override any pending sample. A clk edge during reset SHALL NOT load d.
REQ-021 At the first rising clk edge after rst deasserts, the block SHALL sample d normally. Outputs stay at their reset values until that edge.

Verification
REQ-022 Reset check: assert rst asynchronously between edges while a=11 -> a=00, v=0 and err=0 before the next edge.
REQ-023 One-hot sweep: d=1000, 0100, 0010, 0001, 0000 on successive edges -> one cycle later a=11/10/01/00/00, v=1/1/1/1/0, err=0 throughout.
REQ-024 Priority check: d=1111 -> a=11, v=1, err=1; d=0110 -> a=10, v=1, err=1; d=0011 -> a=01, err=1.
REQ-025 Latency check: change d between edges -> a does not change until the next rising clk edge.
REQ-026 Reset release: hold d=0100 during rst, then release -> a=00 until the first edge, then a=10 and v=1.
REQ-027 Exhaustive check: drive all 16 d values -> a, v and err match the REQ-011 to REQ-014 model, one cycle delayed.
